// File: rtl/tmr_mon_pkg.sv
// Shared types and bit positions for the TMR vote monitor.
// Replica bit order in err/scrub_mask is {A,B,C}.
package tmr_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        REQ  = 2'd2
    } mon_state_t;

    localparam int REP_A = 2;
    localparam int REP_B = 1;
    localparam int REP_C = 0;

endpackage

// File: rtl/tmr_sat_counter.sv
// Saturating up-counter; updates one cycle after inc, holds at all-ones.
// No backpressure; a clear in the same cycle as an increment wins.
module tmr_sat_counter
    import tmr_mon_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             c,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tmr_vote_monitor.sv
// Majority voter over three replicas with per-replica error counters; 1-cycle latency.
// scrub_req holds until scrub_ack; disagreements seen while requesting are not accumulated.
module tmr_vote_monitor
    import tmr_mon_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 8,
    parameter int PERSIST = 2
) (
    input  logic             c,
    input  logic             rst,
    input  logic [WIDTH-1:0] dA,
    input  logic [WIDTH-1:0] dB,
    input  logic [WIDTH-1:0] dC,
    input  logic             clr,
    input  logic             scrub_ack,
    output logic [WIDTH-1:0] q,
    output logic [2:0]       err,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic             multi_fault,
    output logic             scrub_req,
    output logic [2:0]       scrub_mask
);

    localparam int PW = (PERSIST < 2) ? 1 : $clog2(PERSIST + 1);

    logic [WIDTH-1:0] maj;
    logic [2:0]       dis;
    logic             mismatch;
    logic             multi_now;

    assign maj        = (dA & dB) | (dA & dC) | (dB & dC);
    assign dis[REP_A] = (dA != maj);
    assign dis[REP_B] = (dB != maj);
    assign dis[REP_C] = (dC != maj);
    assign mismatch   = |dis;
    assign multi_now  = (dis[0] & dis[1]) | (dis[0] & dis[2]) | (dis[1] & dis[2]);

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            q   <= '0;
            err <= '0;
        end else begin
            q   <= maj;
            err <= dis;
        end
    end

    tmr_sat_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .c(c), .rst(rst), .inc(dis[REP_A]), .clr(clr), .cnt(cnt_a)
    );
    tmr_sat_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .c(c), .rst(rst), .inc(dis[REP_B]), .clr(clr), .cnt(cnt_b)
    );
    tmr_sat_counter #(.CNT_W(CNT_W)) u_cnt_c (
        .c(c), .rst(rst), .inc(dis[REP_C]), .clr(clr), .cnt(cnt_c)
    );

    // A new multi-replica fault outranks a simultaneous clear.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            multi_fault <= 1'b0;
        end else if (multi_now) begin
            multi_fault <= 1'b1;
        end else if (clr) begin
            multi_fault <= 1'b0;
        end
    end

    mon_state_t    state;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_inc;
    logic [2:0]    acc;

    assign pcnt_inc = pcnt + PW'(1);

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pcnt  <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mismatch) begin
                        pcnt  <= PW'(1);
                        acc   <= dis;
                        state <= (PERSIST == 1) ? REQ : ARM;
                    end
                end
                ARM: begin
                    if (mismatch) begin
                        pcnt <= pcnt_inc;
                        acc  <= acc | dis;
                        if (pcnt_inc == PW'(PERSIST)) begin
                            state <= REQ;
                        end
                    end else begin
                        pcnt  <= '0;
                        acc   <= '0;
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (scrub_ack) begin
                        pcnt  <= '0;
                        acc   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    pcnt  <= '0;
                    acc   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from the state register so reset removes the request at once.
    assign scrub_req  = (state == REQ);
    assign scrub_mask = scrub_req ? acc : 3'b000;

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Randomized bench for tmr_vote_monitor: two instances (CNT_W=8/PERSIST=2 and
// CNT_W=2/PERSIST=1) share stimulus and are compared against a behavioural model.
module tb_tmr_vote_monitor;

    logic       c = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] dA = 8'h00;
    logic [7:0] dB = 8'h00;
    logic [7:0] dC = 8'h00;
    logic       clr = 1'b0;
    logic       scrub_ack = 1'b0;

    logic [7:0] q0, q1;
    logic [2:0] err0, err1, mask0, mask1;
    logic [7:0] cnt_a0, cnt_b0, cnt_c0;
    logic [1:0] cnt_a1, cnt_b1, cnt_c1;
    logic       multi0, multi1, req0, req1;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 c = ~c;

    tmr_vote_monitor #(.WIDTH(8), .CNT_W(8), .PERSIST(2)) u0 (
        .c(c), .rst(rst), .dA(dA), .dB(dB), .dC(dC), .clr(clr), .scrub_ack(scrub_ack),
        .q(q0), .err(err0), .cnt_a(cnt_a0), .cnt_b(cnt_b0), .cnt_c(cnt_c0),
        .multi_fault(multi0), .scrub_req(req0), .scrub_mask(mask0)
    );

    tmr_vote_monitor #(.WIDTH(8), .CNT_W(2), .PERSIST(1)) u1 (
        .c(c), .rst(rst), .dA(dA), .dB(dB), .dC(dC), .clr(clr), .scrub_ack(scrub_ack),
        .q(q1), .err(err1), .cnt_a(cnt_a1), .cnt_b(cnt_b1), .cnt_c(cnt_c1),
        .multi_fault(multi1), .scrub_req(req1), .scrub_mask(mask1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model; index 0/1 matches u0/u1, replica index 0=A,1=B,2=C.
    int         cw[2]   = '{8, 2};
    int         pers[2] = '{2, 1};
    logic [7:0] m_q[2]  = '{8'h00, 8'h00};
    logic [2:0] m_err[2] = '{3'b000, 3'b000};
    int         m_cnt[2][3];
    bit         m_multi[2];
    int         m_streak[2];
    logic [2:0] m_acc[2] = '{3'b000, 3'b000};
    bit         m_req[2];

    always @(posedge c or posedge rst) begin : model
        logic [7:0] mj;
        logic [2:0] ds;
        int         ones;
        int         nd;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_q[k] = 8'h00;
                m_err[k] = 3'b000;
                for (int i = 0; i < 3; i++) m_cnt[k][i] = 0;
                m_multi[k] = 1'b0;
                m_streak[k] = 0;
                m_acc[k] = 3'b000;
                m_req[k] = 1'b0;
            end
        end else begin
            mj = 8'h00;
            for (int b = 0; b < 8; b++) begin
                ones = int'(dA[b]) + int'(dB[b]) + int'(dC[b]);
                mj[b] = (ones >= 2);
            end
            ds = {dA != mj, dB != mj, dC != mj};
            nd = int'(ds[0]) + int'(ds[1]) + int'(ds[2]);
            for (int k = 0; k < 2; k++) begin
                m_q[k] = mj;
                m_err[k] = ds;
                for (int i = 0; i < 3; i++) begin
                    if (clr) m_cnt[k][i] = 0;
                    else if (ds[2-i] && m_cnt[k][i] < (1 << cw[k]) - 1) m_cnt[k][i]++;
                end
                if (nd >= 2) m_multi[k] = 1'b1;
                else if (clr) m_multi[k] = 1'b0;
                if (m_req[k]) begin
                    if (scrub_ack) begin
                        m_req[k] = 1'b0;
                        m_streak[k] = 0;
                        m_acc[k] = 3'b000;
                    end
                end else if (nd > 0) begin
                    m_streak[k]++;
                    m_acc[k] = m_acc[k] | ds;
                    if (m_streak[k] >= pers[k]) m_req[k] = 1'b1;
                end else begin
                    m_streak[k] = 0;
                    m_acc[k] = 3'b000;
                end
            end
        end
    end

    always @(negedge c) begin
        if (cmp_en) begin
            check("q0", q0, m_q[0]);
            check("err0", err0, m_err[0]);
            check("cnt_a0", cnt_a0, m_cnt[0][0]);
            check("cnt_b0", cnt_b0, m_cnt[0][1]);
            check("cnt_c0", cnt_c0, m_cnt[0][2]);
            check("multi0", multi0, m_multi[0]);
            check("req0", req0, m_req[0]);
            check("mask0", mask0, m_req[0] ? m_acc[0] : 3'b000);
            check("q1", q1, m_q[1]);
            check("err1", err1, m_err[1]);
            check("cnt_a1", cnt_a1, m_cnt[1][0]);
            check("cnt_b1", cnt_b1, m_cnt[1][1]);
            check("cnt_c1", cnt_c1, m_cnt[1][2]);
            check("multi1", multi1, m_multi[1]);
            check("req1", req1, m_req[1]);
            check("mask1", mask1, m_req[1] ? m_acc[1] : 3'b000);
        end
    end

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] cc);
        dA = a;
        dB = b;
        dC = cc;
    endtask

    task automatic next_cycle();
        @(negedge c);
    endtask

    initial begin
        int exp4[6] = '{1, 2, 3, 3, 3, 3};
        logic [7:0] base;
        int r;

        // Reset with equal replicas present, then release.
        #1 rst = 1'b1;
        drive(8'hA5, 8'hA5, 8'hA5);
        cmp_en = 1'b1;
        next_cycle();
        check("rst_q", q0, 0);
        check("rst_err", err0, 0);
        check("rst_cnt", {cnt_a0, cnt_b0, cnt_c0}, 0);
        check("rst_req", {multi0, req0, mask0}, 0);
        #1 rst = 1'b0;
        next_cycle();
        check("first_q", q0, 8'hA5);

        // Single-cycle B fault does not reach a scrub with PERSIST=2.
        #1 drive(8'h00, 8'h01, 8'h00);
        next_cycle();
        check("t2_err", err0, 3'b010);
        check("t2_cnt_b", cnt_b0, 1);
        check("t2_req", req0, 0);
        #1 drive(8'h00, 8'h00, 8'h00);
        next_cycle();
        check("t2_req_after", req0, 0);

        // Persistent C fault: request after 2 cycles, held until ack.
        #1 drive(8'h00, 8'h00, 8'hFF);
        repeat (2) next_cycle();
        check("t3_req", req0, 1);
        check("t3_mask", mask0, 3'b001);
        repeat (5) next_cycle();
        check("t3_req_held", req0, 1);
        check("t3_cnt_c", cnt_c0, 7);
        #1 scrub_ack = 1'b1;
        next_cycle();
        check("t3_req_drop", req0, 0);
        check("t3_cnt_c_ack", cnt_c0, 8);
        #1 scrub_ack = 1'b0;
        drive(8'h00, 8'h00, 8'h00);
        next_cycle();

        // Saturation on the 2-bit counter, then clear beating an increment.
        #1 drive(8'hFF, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            check("t4_cnt_a1", cnt_a1, exp4[i]);
        end
        #1 clr = 1'b1;
        next_cycle();
        check("t4_clr", cnt_a1, 0);
        #1 clr = 1'b0;

        // Two replicas wrong in different bits: still voted, sticky multi_fault.
        drive(8'h01, 8'h02, 8'h00);
        next_cycle();
        check("t5_q", q0, 8'h00);
        check("t5_err", err0, 3'b110);
        check("t5_multi", multi0, 1);
        #1 drive(8'h00, 8'h00, 8'h00);
        next_cycle();
        check("t5_sticky", multi0, 1);

        // Reset while a request is outstanding removes it immediately.
        #1 drive(8'hFF, 8'h00, 8'h00);
        repeat (2) next_cycle();
        check("t6_pre_req", req0, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_req_async", req0, 0);
        check("t6_mask_async", mask0, 0);
        next_cycle();
        #1 rst = 1'b0;
        drive(8'h00, 8'h00, 8'h00);

        // Random phase.
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            #1;
            base = 8'($urandom);
            dA = base;
            dB = base;
            dC = base;
            r = $urandom_range(0, 9);
            if (r < 4) begin
                case ($urandom_range(0, 2))
                    0: dA[$urandom_range(0, 7)] ^= 1'b1;
                    1: dB[$urandom_range(0, 7)] ^= 1'b1;
                    default: dC[$urandom_range(0, 7)] ^= 1'b1;
                endcase
            end else if (r == 4) begin
                dA ^= 8'($urandom);
                dC ^= 8'($urandom);
            end
            clr = ($urandom_range(0, 49) == 0);
            scrub_ack = ($urandom_range(0, 3) == 0);
        end

        next_cycle();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
